// File: rtl/cpu_defs.sv
// cpu_defs: shared pipeline constants (fetch FSM encoding, PC defaults, stall-vector bit indices).
package cpu_defs;
    localparam int          INST_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam int          STALL_PC     = 0;
    localparam int          STALL_ID     = 2;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    // Instruction addresses are word aligned; the low two bits are discarded.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch.sv
// if_fetch: MIPS instruction-fetch stage; owns the PC and handshakes with the instruction memory.
// Ports: clk, rst (async active-low); stall[5:0], flush/new_pc, branch_flag/branch_target from later stages;
//        inst_req/inst_addr/inst_ack/inst_rdata memory port; stallreq_if to the stall controller;
//        if_pc/if_inst towards the IF/ID register.
module if_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [31:0]       new_pc,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    output logic              inst_req,
    output logic [31:0]       inst_addr,
    input  logic              inst_ack,
    input  logic [INST_W-1:0] inst_rdata,
    output logic              stallreq_if,
    output logic [31:0]       if_pc,
    output logic [INST_W-1:0] if_inst
);
    logic [1:0]        state, state_nx;
    logic [31:0]       pc, pend_target, drop_addr, next_pc;
    logic [INST_W-1:0] inst_buf;
    logic              pend_valid, adv, br_live, stall_pc, req_ack, unused_bits;

    assign stall_pc    = stall[STALL_PC];
    assign br_live     = branch_flag & ~stall[STALL_ID];
    assign req_ack     = (state == S_REQ) & inst_ack;
    assign adv         = (req_ack | (state == S_HOLD)) & ~stall_pc & ~flush;
    assign unused_bits = ^{stall[5:3], stall[1], new_pc[1:0], branch_target[1:0]};

    // A live branch beats a latched one: the latched one belongs to an older delay slot only
    // when no new branch is being resolved this cycle.
    always_comb begin
        next_pc  = br_live ? word_align(branch_target) : pend_valid ? pend_target : pc + PC_INC;
        state_nx = ((state == S_HOLD) | req_ack) & stall_pc ? S_HOLD :
                   (state == S_DROP) & ~inst_ack ? S_DROP : S_REQ;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_BOOT;
            pc          <= word_align(RESET_PC);
            inst_buf    <= NOP_INST;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            drop_addr   <= '0;
        end else if (flush) begin
            // An un-acked request cannot be withdrawn, so wait it out in DROP on its old address.
            pc         <= word_align(new_pc);
            pend_valid <= 1'b0;
            state      <= ((state == S_REQ) | (state == S_DROP)) & ~inst_ack ? S_DROP : S_REQ;
            if (state == S_REQ) drop_addr <= pc;
        end else begin
            state <= state_nx;
            if (adv) begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
            end else if (br_live) begin
                pend_valid  <= 1'b1;
                pend_target <= word_align(branch_target);
            end
            if (req_ack & stall_pc) inst_buf <= inst_rdata;
        end
    end

    always_comb begin
        inst_req    = (state == S_REQ) | (state == S_DROP);
        inst_addr   = (state == S_DROP) ? drop_addr : pc;
        stallreq_if = (state == S_BOOT) | (state == S_DROP) | ((state == S_REQ) & ~inst_ack);
        if_pc       = ~flush & (req_ack | (state == S_HOLD)) ? pc : 32'h0;
        if_inst     = flush ? NOP_INST : req_ack ? inst_rdata : (state == S_HOLD) ? inst_buf : NOP_INST;
    end
endmodule
